// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC request scheduler.
// Binary angles: 2^ANGLE_W is one full turn, so the top two bits give the quadrant.
package cordic_pkg;

  localparam int unsigned CORDIC_ANGLE_W = 32;
  localparam int unsigned CORDIC_DATA_W  = 32;
  localparam int unsigned CORDIC_NUM_REQ = 4;

  localparam logic [CORDIC_ANGLE_W-1:0] ANG_90  = {2'b01, {(CORDIC_ANGLE_W-2){1'b0}}};
  localparam logic [CORDIC_ANGLE_W-1:0] ANG_180 = {2'b10, {(CORDIC_ANGLE_W-2){1'b0}}};

  typedef struct packed {
    logic                              valid;
    logic [$clog2(CORDIC_NUM_REQ)-1:0] id;
  } tag_t;

  // Two's-complement negation that clamps the most negative value instead of wrapping.
  function automatic logic [CORDIC_DATA_W-1:0] sat_neg(input logic [CORDIC_DATA_W-1:0] v);
    if (v == {1'b1, {(CORDIC_DATA_W-1){1'b0}}}) return {1'b0, {(CORDIC_DATA_W-1){1'b1}}};
    return -v;
  endfunction

endpackage

// File: rtl/cordic_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first eligible requester at or after the pointer,
// then moves the pointer one past the winner.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] elig_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o,
  output logic               grant_vld_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;

  always_comb begin : pick
    int unsigned idx;
    idx         = 0;
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(ptr_q) + off) % NUM_REQ;
      if (!grant_vld_o && elig_i[idx]) begin
        grant_vld_o  = 1'b1;
        grant_idx_o  = ID_W'(idx);
        grant_o[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = (grant_idx_o == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx_o + ID_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              ptr_q <= '0;
    else if (grant_vld_o) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one pipelined rotation-mode CORDIC core among NUM_REQ requesters: round-robin
// issue with quadrant folding, a tag pipe tracking ops in flight, and per-requester result routing.
module cordic_scheduler
  import cordic_pkg::*;
#(
  parameter int unsigned NUM_REQ    = CORDIC_NUM_REQ,
  parameter int unsigned DATA_W     = CORDIC_DATA_W,
  parameter int unsigned ANGLE_W    = CORDIC_ANGLE_W,
  parameter int unsigned CORDIC_LAT = 32,
  parameter int unsigned MAX_OUT    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ANGLE_W-1:0] req_angle,
  input  logic [NUM_REQ*DATA_W-1:0]  req_x,
  input  logic [NUM_REQ*DATA_W-1:0]  req_y,
  output logic [ANGLE_W-1:0]         core_angle,
  output logic [DATA_W-1:0]          core_x,
  output logic [DATA_W-1:0]          core_y,
  input  logic [DATA_W-1:0]          core_x_o,
  input  logic [DATA_W-1:0]          core_y_o,
  output logic [NUM_REQ-1:0]         res_valid,
  output logic [DATA_W-1:0]          res_x,
  output logic [DATA_W-1:0]          res_y,
  output logic                       busy
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [DATA_W-1:0]  D_MIN     = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]  D_MAX     = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [ANGLE_W-1:0] HALF_TURN = {1'b1, {(ANGLE_W-1){1'b0}}};

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } slot_t;

  function automatic logic [DATA_W-1:0] neg_sat(input logic [DATA_W-1:0] v);
    return (v == D_MIN) ? D_MAX : -v;
  endfunction

  logic [NUM_REQ-1:0] elig, grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_vld;
  logic [CNT_W-1:0]   cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   cnt_d [NUM_REQ];
  slot_t              issue_q;
  slot_t              pipe_q [CORDIC_LAT];
  slot_t              tail;
  logic [ANGLE_W-1:0] sel_angle, fold_angle;
  logic [DATA_W-1:0]  sel_x, sel_y, fold_x, fold_y;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      elig[i] = req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT)) && en;
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .elig_i      (elig),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  assign req_ready = grant;

  // Quadrants 1 and 2 are rotated by 180deg (angle + half turn, vector negated) into [-90,+90).
  always_comb begin
    sel_angle  = req_angle[32'(grant_idx) * ANGLE_W +: ANGLE_W];
    sel_x      = req_x[32'(grant_idx) * DATA_W +: DATA_W];
    sel_y      = req_y[32'(grant_idx) * DATA_W +: DATA_W];
    fold_angle = sel_angle;
    fold_x     = sel_x;
    fold_y     = sel_y;
    if (sel_angle[ANGLE_W-1] ^ sel_angle[ANGLE_W-2]) begin
      fold_angle = sel_angle + HALF_TURN;
      fold_x     = neg_sat(sel_x);
      fold_y     = neg_sat(sel_y);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_angle <= '0;
      core_x     <= '0;
      core_y     <= '0;
      issue_q    <= '0;
    end else begin
      issue_q <= {grant_vld, grant_idx};
      if (grant_vld) begin
        core_angle <= fold_angle;
        core_x     <= fold_x;
        core_y     <= fold_y;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CORDIC_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= issue_q;
      for (int unsigned i = 1; i < CORDIC_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail = pipe_q[CORDIC_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= '0;
      res_x     <= '0;
      res_y     <= '0;
    end else begin
      res_valid <= tail.valid ? (NUM_REQ'(1) << tail.id) : '0;
      res_x     <= core_x_o;
      res_y     <= core_y_o;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      case ({grant[i], res_valid[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    busy = issue_q.valid;
    for (int unsigned i = 0; i < CORDIC_LAT; i++) busy = busy | pipe_q[i].valid;
    for (int unsigned i = 0; i < NUM_REQ; i++)    busy = busy | (cnt_q[i] != '0);
  end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench for cordic_scheduler; the core is modelled as a pure CORDIC_LAT-cycle delay line.
module tb_cordic_scheduler;

  localparam int unsigned NR  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned LAT = 32;
  localparam int unsigned MO  = 8;

  logic             clk, rst, en;
  logic [NR-1:0]    req_valid, req_ready, res_valid;
  logic [NR*AW-1:0] req_angle;
  logic [NR*DW-1:0] req_x, req_y;
  logic [AW-1:0]    core_angle;
  logic [DW-1:0]    core_x, core_y, core_x_o, core_y_o, res_x, res_y;
  logic             busy;

  cordic_scheduler #(
    .NUM_REQ    (NR),
    .DATA_W     (DW),
    .ANGLE_W    (AW),
    .CORDIC_LAT (LAT),
    .MAX_OUT    (MO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_angle  (req_angle),
    .req_x      (req_x),
    .req_y      (req_y),
    .core_angle (core_angle),
    .core_x     (core_x),
    .core_y     (core_y),
    .core_x_o   (core_x_o),
    .core_y_o   (core_y_o),
    .res_valid  (res_valid),
    .res_x      (res_x),
    .res_y      (res_y),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] dlx [LAT];
  logic [DW-1:0] dly [LAT];
  always @(posedge clk) begin
    dlx[0] <= core_x;
    dly[0] <= core_y;
    for (int k = 1; k < LAT; k++) begin
      dlx[k] <= dlx[k-1];
      dly[k] <= dly[k-1];
    end
  end
  assign core_x_o = dlx[LAT-1];
  assign core_y_o = dly[LAT-1];

  typedef struct {
    int unsigned   id;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    int            due;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int unsigned id, input logic [DW-1:0] x, input logic [DW-1:0] y);
    exp_t e;
    e.id  = id;
    e.x   = x;
    e.y   = y;
    e.due = cyc + LAT + 2;
    exp_q.push_back(e);
  endtask

  // Result scoreboard: every strobe must match the oldest pending op, on its due cycle.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (res_valid != '0) begin
        if (exp_q.size() == 0) begin
          chk("res_spurious", 64'(res_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("res_onehot", 64'(res_valid), 64'(4'b0001 << mon_e.id));
          chk("res_x", 64'(res_x), 64'(mon_e.x));
          chk("res_y", 64'(res_y), 64'(mon_e.y));
          chk("res_cycle", 64'(cyc), 64'(mon_e.due));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        mon_e = exp_q.pop_front();
        chk("res_missing", 64'(res_valid), 64'(4'b0001 << mon_e.id));
      end
    end
  end

  task automatic clear_inputs();
    req_valid = '0;
    req_angle = '0;
    req_x     = '0;
    req_y     = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      #3;
      k++;
    end
    chk({nm, "_drain"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    #1;
    chk({nm, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic single_op(input string nm, input int unsigned id,
                           input logic [AW-1:0] ang, input logic [DW-1:0] x, input logic [DW-1:0] y,
                           input logic [AW-1:0] e_ang, input logic [DW-1:0] e_x, input logic [DW-1:0] e_y);
    @(negedge clk);
    req_valid              = NR'(1) << id;
    req_angle[id*AW +: AW] = ang;
    req_x[id*DW +: DW]     = x;
    req_y[id*DW +: DW]     = y;
    #1;
    chk({nm, "_ready"}, 64'(req_ready), 64'(NR'(1) << id));
    push_exp(id, e_x, e_y);
    @(negedge clk);
    clear_inputs();
    #1;
    chk({nm, "_core_angle"}, 64'(core_angle), 64'(e_ang));
    chk({nm, "_core_x"}, 64'(core_x), 64'(e_x));
    chk({nm, "_core_y"}, 64'(core_y), 64'(e_y));
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    drain(nm, 60);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int out_n;
    int acc_n;
    logic [NR-1:0] exp_rdy;
    rst = 1'b1;
    en  = 1'b0;
    clear_inputs();

    @(negedge clk);
    #1;
    chk("rst_core_angle", 64'(core_angle), 64'd0);
    chk("rst_core_x", 64'(core_x), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_x", 64'(res_x), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    single_op("t1_q0", 0, 32'h2000_0000, 32'd1000, 32'd0,
              32'h2000_0000, 32'd1000, 32'd0);
    single_op("t2_q2", 1, 32'hA000_0000, 32'd1000, 32'hFFFF_FFFB,
              32'h2000_0000, 32'hFFFF_FC18, 32'd5);
    single_op("t3_sat", 2, 32'h9000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
              32'h1000_0000, 32'h7FFF_FFFF, 32'h8000_0001);
    single_op("t3_q1", 3, 32'h4000_0000, 32'd7, 32'hFFFF_FFFD,
              32'hC000_0000, 32'hFFFF_FFF9, 32'd3);
    single_op("t3_q3", 0, 32'hE000_0000, 32'd12, 32'd34,
              32'hE000_0000, 32'd12, 32'd34);

    // All four requesters contending: strict 0,1,2,3 rotation after reset.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      req_valid = '1;
      for (int unsigned i = 0; i < NR; i++) begin
        req_angle[i*AW +: AW] = 32'h1000_0000 + i;
        req_x[i*DW +: DW]     = 1000 * i + k;
        req_y[i*DW +: DW]     = k;
      end
      #1;
      chk("t4_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      push_exp(k % 4, 1000 * (k % 4) + k, k);
    end
    @(negedge clk);
    clear_inputs();
    drain("t4", 80);

    // One requester saturating its outstanding limit.
    do_reset();
    out_n = 0;
    acc_n = 0;
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      req_valid             = 4'b0100;
      req_angle[2*AW +: AW] = 32'h0800_0000;
      req_x[2*DW +: DW]     = 2000 + c;
      req_y[2*DW +: DW]     = c;
      #1;
      exp_rdy = ((c < 8) || (c >= 35 && c <= 42)) ? 4'b0100 : 4'b0000;
      chk("t5_ready", 64'(req_ready), 64'(exp_rdy));
      if (req_ready[2]) begin
        push_exp(2, 2000 + c, c);
        out_n++;
        if (c < 35) acc_n++;
      end
      if (res_valid[2]) out_n--;
      chk("t5_inflight_le_max", 64'(out_n <= MO), 64'd1);
    end
    chk("t5_accepts_before_return", 64'(acc_n), 64'd8);
    @(negedge clk);
    clear_inputs();
    drain("t5", 100);

    // Ten ops in flight, issue disabled, then reset discards them.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = '1;
      for (int unsigned i = 0; i < NR; i++) begin
        req_angle[i*AW +: AW] = 32'h0400_0000;
        req_x[i*DW +: DW]     = 3000 + c;
        req_y[i*DW +: DW]     = i;
      end
      #1;
      chk("t6_grant", 64'(req_ready), 64'(4'b0001 << (c % 4)));
      push_exp(c % 4, 3000 + c, c % 4);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      en = 1'b0;
      #1;
      chk("t6_en_off_ready", 64'(req_ready), 64'd0);
      chk("t6_en_off_busy", 64'(busy), 64'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    #1;
    exp_q.delete();
    chk("t6_rst_core_angle", 64'(core_angle), 64'd0);
    chk("t6_rst_core_x", 64'(core_x), 64'd0);
    chk("t6_rst_core_y", 64'(core_y), 64'd0);
    chk("t6_rst_res_valid", 64'(res_valid), 64'd0);
    chk("t6_rst_res_x", 64'(res_x), 64'd0);
    chk("t6_rst_res_y", 64'(res_y), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      #1;
      chk("t6_no_res", 64'(res_valid), 64'd0);
    end
    chk("t6_busy_after", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
